// File: rtl/pwm_pkg.sv
// pwm_pkg: types and constants shared by the PWM generator and capture blocks
package pwm_pkg;
  localparam int PWM_WIDTH = 8;
  typedef enum logic [1:0] {ACQUIRE, HIGH, LOW} capture_state_e;
  function automatic int pwm_period(input int width);
    return 1 << width;
  endfunction
endpackage

// File: rtl/sync_edge.sv
// sync_edge: 2-FF synchronizer plus registered rise/fall pulses for one async input
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  logic [2:0] sync_q;
  logic       rise_q;
  logic       fall_q;
  // sync_q[1:0] resolve metastability, sync_q[2] is the previous synchronized value
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], async_i};
      rise_q <= sync_q[1] & ~sync_q[2];
      fall_q <= ~sync_q[1] & sync_q[2];
    end
  end
  assign level_o = sync_q[2];
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: recovers the duty level of a 2**WIDTH-clock PWM waveform
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int WIDTH  = PWM_WIDTH,
  parameter int TOL    = 2,
  parameter int LOCK_N = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] level,
  output logic             valid,
  output logic             locked,
  output logic             period_err
);
  localparam int CW = WIDTH + 1;
  localparam int GW = $clog2(LOCK_N + 1);
  localparam logic [CW-1:0]    PER_MIN  = CW'(pwm_period(WIDTH) - TOL);
  localparam logic [CW-1:0]    PER_MAX  = CW'(pwm_period(WIDTH) + TOL);
  localparam logic [WIDTH-1:0] LVL_MAX  = '1;
  localparam logic [GW-1:0]    LOCK_CNT = GW'(LOCK_N);

  capture_state_e   state_q;
  logic [CW-1:0]    hi_q, per_q, hi_inc, per_inc;
  logic [GW-1:0]    good_q, good_d;
  logic             sync_lvl, rise, fall;
  logic             timeout, evaluate, accept, reject;
  logic [WIDTH-1:0] meas_lvl, level_d;

  sync_edge u_sync (
    .clk    (clk),
    .reset  (reset),
    .async_i(pwm_in),
    .level_o(sync_lvl),
    .rise_o (rise),
    .fall_o (fall)
  );

  // A rise closes the running period; a static input is reported as 0 or full
  // scale once the period count would pass PERIOD+TOL
  always_comb begin
    per_inc  = &per_q ? per_q : per_q + 1'b1;
    hi_inc   = &hi_q ? hi_q : hi_q + 1'b1;
    timeout  = ~rise & (per_q == PER_MAX);
    evaluate = rise & (state_q != ACQUIRE);
    accept   = (evaluate & (per_q >= PER_MIN) & (per_q <= PER_MAX)) | timeout;
    reject   = evaluate & ~accept;
    meas_lvl = (hi_q > CW'(LVL_MAX)) ? LVL_MAX : hi_q[WIDTH-1:0];
    level_d  = timeout ? (sync_lvl ? LVL_MAX : '0) : meas_lvl;
    good_d   = reject ? '0 : (accept && good_q != LOCK_CNT) ? good_q + 1'b1 : good_q;
  end

  // Measurement FSM, counters and registered outputs; a rise both evaluates and restarts
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ACQUIRE;
      hi_q       <= '0;
      per_q      <= '0;
      good_q     <= '0;
      level      <= '0;
      valid      <= 1'b0;
      locked     <= 1'b0;
      period_err <= 1'b0;
    end else begin
      valid      <= accept;
      period_err <= reject;
      good_q     <= good_d;
      locked     <= (good_d == LOCK_CNT);
      if (accept) level <= level_d;
      if (rise) begin
        state_q <= HIGH;
        hi_q    <= CW'(1);
        per_q   <= CW'(1);
      end else if (timeout) begin
        state_q <= ACQUIRE;
        hi_q    <= '0;
        per_q   <= '0;
      end else begin
        per_q <= per_inc;
        if (state_q == HIGH) begin
          if (fall) state_q <= LOW;
          else hi_q <= hi_inc;
        end
      end
    end
  end
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: scenario tasks against a time-stamp based reference model
module tb_pwm_capture;
  localparam int W      = 8;
  localparam int PERIOD = 256;
  localparam int TOL    = 2;
  localparam int LOCK_N = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         pwm_in = 1'b0;
  logic [W-1:0] level;
  logic         valid, locked, period_err;

  pwm_capture #(.WIDTH(W), .TOL(TOL), .LOCK_N(LOCK_N)) dut (
    .clk       (clk),
    .reset     (reset),
    .pwm_in    (pwm_in),
    .level     (level),
    .valid     (valid),
    .locked    (locked),
    .period_err(period_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int g_per = 256, g_hi = 0, g_cnt = 0;

  // Reference model: works on sample times of the input as seen after the
  // three-flop input delay, measuring periods as rise-to-rise time differences
  logic [3:0]   hx = '0;
  bit           acq = 1'b1;
  int           tnow = 0, zero = 0, rise_t = 0, fall_t = 0, good_n = 0;
  logic [W-1:0] e_level = '0;
  logic         e_valid = 1'b0, e_err = 1'b0, e_locked = 1'b0;

  always @(posedge clk) begin : model
    int   cnt;
    logic r, f;
    tnow++;
    e_valid = 1'b0;
    e_err   = 1'b0;
    if (reset) begin
      hx = '0; acq = 1'b1; zero = tnow; good_n = 0; e_level = '0; e_locked = 1'b0;
    end else begin
      r   = hx[2] & ~hx[3];
      f   = ~hx[2] & hx[3];
      cnt = tnow - 1 - zero;
      if (r) begin
        if (!acq) begin
          if (cnt >= PERIOD - TOL && cnt <= PERIOD + TOL) begin
            e_valid = 1'b1;
            e_level = W'((fall_t - rise_t) > 255 ? 255 : (fall_t - rise_t));
          end else e_err = 1'b1;
        end
        acq = 1'b0; rise_t = tnow; zero = tnow - 1;
      end else if (cnt == PERIOD + TOL) begin
        e_valid = 1'b1;
        e_level = hx[2] ? 8'd255 : 8'd0;
        acq = 1'b1; zero = tnow;
      end
      if (f) fall_t = tnow;
      if (e_valid) good_n = good_n < LOCK_N ? good_n + 1 : LOCK_N;
      if (e_err) good_n = 0;
      e_locked = (good_n == LOCK_N);
      hx = {hx[2:0], pwm_in};
    end
  end

  task automatic gen();
    pwm_in = (g_cnt < g_hi);
    g_cnt  = (g_cnt + 1 >= g_per) ? 0 : g_cnt + 1;
  endtask

  task automatic cyc();
    @(negedge clk);
    gen();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({level, valid, locked, period_err} !== '0) $display("FAIL reset_outputs got=%h exp=0", {level, valid, locked, period_err});
      else passed++;
      pwm_in = 1'($urandom);
    end
    @(negedge clk);
    reset = 1'b0; g_per = 256; g_hi = 128; g_cnt = 0;
    gen();
  endtask

  task automatic test_loopback_128();
    int nv = 0, last = 0;
    for (int i = 1; i <= 1300; i++) begin
      cyc();
      checks++;
      if ({level, valid, locked, period_err} !== {e_level, e_valid, e_locked, e_err}) $display("FAIL model_loop t=%0d got=%h exp=%h", i, {level, valid, locked, period_err}, {e_level, e_valid, e_locked, e_err});
      else passed++;
      if (valid) begin
        nv++;
        checks++;
        if (level !== 8'd128 || locked !== (nv >= LOCK_N)) $display("FAIL loop_valid n=%0d level=%0d locked=%b exp 128/%b", nv, level, locked, nv >= LOCK_N);
        else passed++;
        checks++;
        if (nv == 1 ? i > 2 * PERIOD : i - last != PERIOD) $display("FAIL loop_timing n=%0d at=%0d prev=%0d", nv, i, last);
        else passed++;
        last = i;
      end
    end
    checks++;
    if (nv < 4) $display("FAIL loop_count got=%0d exp>=4", nv);
    else passed++;
  endtask

  task automatic test_extremes();
    int p = 0, n_err = 0;
    for (int i = 0; i < 8 * PERIOD && p < 7; i++) begin
      if (g_cnt == 0) begin
        p++;
        if (p == 4) begin
          checks++;
          if (level !== 8'd1) $display("FAIL level_one got=%0d exp=1", level);
          else passed++;
        end
        g_hi = p <= 3 ? 1 : 255;
      end
      cyc();
      checks++;
      if ({level, valid, locked, period_err} !== {e_level, e_valid, e_locked, e_err}) $display("FAIL model_ext t=%0d got=%h exp=%h", i, {level, valid, locked, period_err}, {e_level, e_valid, e_locked, e_err});
      else passed++;
      if (period_err) n_err++;
    end
    checks++;
    if (level !== 8'd255 || n_err != 0) $display("FAIL level_full got=%0d errs=%0d exp 255/0", level, n_err);
    else passed++;
  endtask

  task automatic test_steady(input int hi, input logic [W-1:0] lvl);
    int nv = 0, last = 0;
    g_hi = hi;
    for (int i = 0; i < 1100; i++) begin
      cyc();
      checks++;
      if ({level, valid, locked, period_err} !== {e_level, e_valid, e_locked, e_err}) $display("FAIL model_steady t=%0d got=%h exp=%h", i, {level, valid, locked, period_err}, {e_level, e_valid, e_locked, e_err});
      else passed++;
      if (valid && i >= 4) begin
        nv++;
        checks++;
        if (level !== lvl || (nv > 1 && i - last != PERIOD + TOL + 1)) $display("FAIL steady_valid n=%0d level=%0d gap=%0d exp %0d/%0d", nv, level, i - last, lvl, PERIOD + TOL + 1);
        else passed++;
        last = i;
      end
    end
    checks++;
    if (nv < 3) $display("FAIL steady_count got=%0d exp>=3", nv);
    else passed++;
  endtask

  task automatic test_bad_period();
    int p = 0, n_err = 0;
    bit saw = 1'b0;
    for (int i = 0; i < 13 * PERIOD; i++) begin
      if (g_cnt == 0) begin
        p++;
        g_per = p == 7 ? 250 : p == 11 ? 257 : 256;
        g_hi  = p == 11 ? 100 : 128;
      end
      cyc();
      checks++;
      if ({level, valid, locked, period_err} !== {e_level, e_valid, e_locked, e_err}) $display("FAIL model_bad t=%0d got=%h exp=%h", i, {level, valid, locked, period_err}, {e_level, e_valid, e_locked, e_err});
      else passed++;
      if (period_err) begin
        n_err++;
        checks++;
        if (level !== 8'd128 || locked !== 1'b0 || valid !== 1'b0) $display("FAIL bad_err level=%0d locked=%b valid=%b exp 128/0/0", level, locked, valid);
        else passed++;
      end
      if (valid && level == 8'd100) saw = 1'b1;
    end
    checks++;
    if (n_err != 1 || !saw) $display("FAIL bad_summary errs=%0d seen257=%b exp 1/1", n_err, saw);
    else passed++;
    g_per = 256; g_hi = 128;
  endtask

  task automatic test_reset_mid();
    int first = -1;
    for (int i = 0; i < 600 && g_cnt != 40; i++) begin
      cyc();
      checks++;
      if ({level, valid, locked, period_err} !== {e_level, e_valid, e_locked, e_err}) $display("FAIL model_pre t=%0d got=%h exp=%h", i, {level, valid, locked, period_err}, {e_level, e_valid, e_locked, e_err});
      else passed++;
    end
    @(negedge clk);
    reset  = 1'b1;
    pwm_in = ~pwm_in;
    @(negedge clk);
    checks++;
    if ({level, valid, locked, period_err} !== '0) $display("FAIL midreset_outputs got=%h exp=0", {level, valid, locked, period_err});
    else passed++;
    reset = 1'b0;
    gen();
    for (int i = 1; i <= 800; i++) begin
      cyc();
      checks++;
      if ({level, valid, locked, period_err} !== {e_level, e_valid, e_locked, e_err}) $display("FAIL model_mid t=%0d got=%h exp=%h", i, {level, valid, locked, period_err}, {e_level, e_valid, e_locked, e_err});
      else passed++;
      if (valid && first < 0) begin
        first = i;
        checks++;
        if (i < PERIOD || level !== 8'd128) $display("FAIL midreset_first at=%0d level=%0d exp >=%0d/128", i, level, PERIOD);
        else passed++;
      end
    end
    checks++;
    if (first < 0) $display("FAIL midreset_none got=none exp=valid");
    else passed++;
  endtask

  task automatic test_level_step();
    int p = 0;
    for (int i = 0; i < 15 * PERIOD; i++) begin
      if (g_cnt == 0) begin
        p++;
        g_hi = p <= 6 ? 64 : 192;
      end
      cyc();
      checks++;
      if ({level, valid, locked, period_err} !== {e_level, e_valid, e_locked, e_err}) $display("FAIL model_step t=%0d got=%h exp=%h", i, {level, valid, locked, period_err}, {e_level, e_valid, e_locked, e_err});
      else passed++;
      checks++;
      if (valid && period_err) $display("FAIL step_both got=11 exp=not both");
      else passed++;
      if (p >= 7) begin
        checks++;
        if (locked !== 1'b1 || (valid && level !== 8'd192 && (p >= 8 || level !== 8'd64))) $display("FAIL step_hold p=%0d locked=%b level=%0d exp 1/192", p, locked, level);
        else passed++;
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 26 * 260; i++) begin
      if (g_cnt == 0) begin
        g_per = 252 + int'($urandom_range(0, 8));
        g_hi  = int'($urandom_range(0, g_per));
      end
      cyc();
      checks++;
      if ({level, valid, locked, period_err} !== {e_level, e_valid, e_locked, e_err}) $display("FAIL model_rand t=%0d got=%h exp=%h", i, {level, valid, locked, period_err}, {e_level, e_valid, e_locked, e_err});
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_loopback_128();
    test_extremes();
    test_steady(0, 8'd0);
    test_steady(300, 8'd255);
    test_bad_period();
    test_reset_mid();
    test_level_step();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
